// File: rtl/sram_resp_pkg.sv
// rtl/sram_resp_pkg.sv - shared types and constants for the SRAM responder
package sram_resp_pkg;

    localparam int DEF_AW    = 8;
    localparam int DEF_DW    = 8;
    localparam int DEF_CNT_W = 16;

    // cen/oen/wen are driven active low by the CPU controller
    localparam logic STB_ACTIVE = 1'b0;
    localparam logic STB_IDLE   = 1'b1;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/sram_arr.sv
// rtl/sram_arr.sv - 2**AW x DW array, one write port, asynchronous read port
module sram_arr #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    // write port; no reset so contents survive rst and reload
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sram_resp.sv
// rtl/sram_resp.sv - SRAM-side responder with boot loader, access counters and error flag
module sram_resp
    import sram_resp_pkg::*;
#(
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int BOOT_LOAD = 1,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    din,
    input  logic             cen,
    input  logic             oen,
    input  logic             wen,
    input  logic             den,
    output logic [DW-1:0]    dq,
    input  logic             ld_valid,
    input  logic [DW-1:0]    ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    input  logic             reload,
    output logic             cpu_rst_n,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt,
    output logic             err
);

    localparam state_e RST_STATE = (BOOT_LOAD != 0) ? ST_LOAD : ST_RUN;
    localparam logic   RST_CPU_N = (BOOT_LOAD == 0);

    state_e           state_q, state_d;
    logic [AW-1:0]    ld_ptr_q, ld_ptr_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             err_q, err_d;

    logic             in_load, ld_accept, ld_done;
    logic             rd_hit, wr_hit, proto_err;
    logic             arr_we;
    logic [AW-1:0]    arr_waddr;
    logic [DW-1:0]    arr_wdata, arr_rdata;

    // strobes only mean anything in RUN; the loader owns the array in LOAD
    assign in_load   = (state_q == ST_LOAD);
    assign ld_accept = in_load && ld_valid;
    assign ld_done   = ld_last || (ld_ptr_q == {AW{1'b1}});
    assign rd_hit    = !in_load && (cen == STB_ACTIVE) && (oen == STB_ACTIVE) && (wen == STB_IDLE);
    assign wr_hit    = !in_load && (cen == STB_ACTIVE) && (wen == STB_ACTIVE) && den;
    // write strobe without chip enable or data, or fighting an output enable
    assign proto_err = !in_load && (wen == STB_ACTIVE) &&
                       ((cen == STB_IDLE) || !den || (oen == STB_ACTIVE));

    assign arr_we    = ld_accept || wr_hit;
    assign arr_waddr = in_load ? ld_ptr_q : addr;
    assign arr_wdata = in_load ? ld_data : din;

    sram_arr #(.AW(AW), .DW(DW)) u_arr (
        .clk   (clk),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .raddr (addr),
        .rdata (arr_rdata)
    );

    assign dq        = rd_hit ? arr_rdata : '0;
    assign ld_ready  = in_load;
    assign cpu_rst_n = cpu_rst_n_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
    assign err       = err_q;

    // next state: load sequencing, reload, saturating counters, sticky error
    always_comb begin
        state_d  = state_q;
        ld_ptr_d = ld_ptr_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q || proto_err;
        if (in_load) begin
            if (ld_accept) begin
                if (ld_done) begin
                    state_d  = ST_RUN;
                    ld_ptr_d = '0;
                end else begin
                    ld_ptr_d = ld_ptr_q + AW'(1);
                end
            end
        end else begin
            if (reload) begin
                state_d  = ST_LOAD;
                ld_ptr_d = '0;
            end
            if (rd_hit && (rd_cnt_q != {CNT_W{1'b1}})) begin
                rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            if (wr_hit && (wr_cnt_q != {CNT_W{1'b1}})) begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
        // CPU is held in reset whenever the next state is LOAD
        cpu_rst_n_d = (state_d == ST_RUN);
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RST_STATE;
            ld_ptr_q    <= '0;
            cpu_rst_n_q <= RST_CPU_N;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_ptr_q    <= ld_ptr_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_resp.sv
// tb/tb_sram_resp.sv - randomized model-checked bench for sram_resp
module tb_sram_resp;

    localparam int DEPTH = 256;
    localparam int CMAX  = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic [7:0]  addr = '0;
    logic [7:0]  din = '0;
    logic [7:0]  ld_data = '0;
    logic        cen = 1'b1, oen = 1'b1, wen = 1'b1, den = 1'b0;
    logic        ld_valid = 1'b0, ld_last = 1'b0, reload = 1'b0;

    logic [7:0]  dq, dq4;
    logic        ld_ready, cpu_rst_n, err;
    logic        ld_ready4, cpu_rst_n4, err4;
    logic [15:0] rd_cnt, wr_cnt;
    logic [2:0]  rd_cnt4, wr_cnt4;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_resp #(.AW(8), .DW(8), .BOOT_LOAD(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din),
        .cen(cen), .oen(oen), .wen(wen), .den(den), .dq(dq),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .reload(reload), .cpu_rst_n(cpu_rst_n),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .err(err)
    );

    sram_resp #(.AW(4), .DW(8), .BOOT_LOAD(1), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst4), .addr(addr[3:0]), .din(din),
        .cen(cen), .oen(oen), .wen(wen), .den(den), .dq(dq4),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready4),
        .reload(reload), .cpu_rst_n(cpu_rst_n4),
        .rd_cnt(rd_cnt4), .wr_cnt(wr_cnt4), .err(err4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] e);
        addr = a; cen = 1'b0; oen = 1'b0; wen = 1'b1; den = 1'b0;
        @(negedge clk);
        chk(name, {24'h0, dq}, {24'h0, e});
        tick();
        cen = 1'b1; oen = 1'b1;
    endtask

    logic [7:0] m_mem [DEPTH];
    bit         m_vld [DEPTH];
    bit         m_load, m_cpu, m_err;
    int         m_ptr, m_rd, m_wr;

    // reference model: what the responder must hold after each edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_load <= 1'b1; m_cpu <= 1'b0; m_err <= 1'b0;
            m_ptr <= 0; m_rd <= 0; m_wr <= 0;
        end else if (m_load) begin
            if (ld_valid) begin
                m_mem[m_ptr] <= ld_data;
                m_vld[m_ptr] <= 1'b1;
                if (ld_last || m_ptr == DEPTH - 1) begin
                    m_load <= 1'b0; m_cpu <= 1'b1; m_ptr <= 0;
                end else begin
                    m_ptr <= m_ptr + 1;
                end
            end
        end else begin
            if (reload) begin
                m_load <= 1'b1; m_cpu <= 1'b0; m_ptr <= 0;
            end
            if (!cen && !oen && wen) m_rd <= m_rd + 1;
            if (!cen && !wen && den) begin
                m_mem[addr] <= din;
                m_vld[addr] <= 1'b1;
                m_wr <= m_wr + 1;
            end
            if (!wen && (cen || !den || !oen)) m_err <= 1'b1;
        end
    end

    // every cycle out of reset the outputs must agree with the model
    always @(negedge clk) begin
        if (chk_en && rst) begin
            logic rd;
            rd = !m_load && !cen && !oen && wen;
            if (!(rd && !m_vld[addr])) chk("dq", {24'h0, dq}, {24'h0, rd ? m_mem[addr] : 8'h00});
            chk("ld_ready", {31'h0, ld_ready}, {31'h0, m_load});
            chk("cpu_rst_n", {31'h0, cpu_rst_n}, {31'h0, m_cpu});
            chk("rd_cnt", {16'h0, rd_cnt}, (m_rd > CMAX) ? CMAX : m_rd);
            chk("wr_cnt", {16'h0, wr_cnt}, (m_wr > CMAX) ? CMAX : m_wr);
            chk("err", {31'h0, err}, {31'h0, m_err});
            chk("ld_ptr", {24'h0, dut.ld_ptr_q}, {24'h0, m_ptr[7:0]});
        end
    end

    initial begin
        #2;
        rst = 1'b0; rst4 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset ld_ready", {31'h0, ld_ready}, 32'd1);
        chk("reset cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
        chk("reset dq", {24'h0, dq}, 32'd0);
        chk("reset rd_cnt", {16'h0, rd_cnt}, 32'd0);
        chk("reset err", {31'h0, err}, 32'd0);
        tick();

        // boot load of three bytes, last marker on the third
        ld_valid = 1'b1; ld_data = 8'h4A; tick();
        ld_data = 8'h21; tick();
        chk("boot ld_ready@2", {31'h0, ld_ready}, 32'd1);
        chk("boot cpu_rst_n@2", {31'h0, cpu_rst_n}, 32'd0);
        ld_data = 8'hC0; ld_last = 1'b1; tick();
        chk("boot ld_ready@3", {31'h0, ld_ready}, 32'd0);
        chk("boot cpu_rst_n@3", {31'h0, cpu_rst_n}, 32'd1);
        ld_valid = 1'b0; ld_last = 1'b0;

        rd_chk("read 0x01", 8'h01, 8'h21);
        chk("read rd_cnt", {16'h0, rd_cnt}, 32'd1);
        rd_chk("read 0x00", 8'h00, 8'h4A);

        // write then read back the next cycle
        addr = 8'h80; din = 8'h5A; cen = 1'b0; wen = 1'b0; den = 1'b1; tick();
        wen = 1'b1; den = 1'b0; cen = 1'b1;
        chk("write wr_cnt", {16'h0, wr_cnt}, 32'd1);
        rd_chk("readback 0x80", 8'h80, 8'h5A);

        // write and output enable together: write wins, dq stays 0
        addr = 8'h10; din = 8'h77; cen = 1'b0; wen = 1'b0; oen = 1'b0; den = 1'b1;
        @(negedge clk);
        chk("wr+oe dq", {24'h0, dq}, 32'd0);
        tick();
        wen = 1'b1; den = 1'b0; cen = 1'b1; oen = 1'b1;
        chk("wr+oe err", {31'h0, err}, 32'd1);
        chk("wr+oe wr_cnt", {16'h0, wr_cnt}, 32'd2);
        rd_chk("readback 0x10", 8'h10, 8'h77);

        // reload, two bytes, then reset mid-load
        reload = 1'b1; tick(); reload = 1'b0;
        chk("reload cpu_rst_n", {31'h0, cpu_rst_n}, 32'd0);
        chk("reload ld_ready", {31'h0, ld_ready}, 32'd1);
        ld_valid = 1'b1; ld_data = 8'hE1; tick();
        ld_data = 8'hE2; tick();
        ld_valid = 1'b0;
        rst = 1'b0; tick(); rst = 1'b1;
        chk("rst ld_ptr", {24'h0, dut.ld_ptr_q}, 32'd0);
        chk("rst rd_cnt", {16'h0, rd_cnt}, 32'd0);
        chk("rst wr_cnt", {16'h0, wr_cnt}, 32'd0);
        chk("rst err", {31'h0, err}, 32'd0);
        ld_valid = 1'b1; ld_data = 8'h99; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        rd_chk("intact 0x02", 8'h02, 8'hC0);
        rd_chk("intact 0x01", 8'h01, 8'hE2);
        rd_chk("intact 0x80", 8'h80, 8'h5A);
        rd_chk("intact 0x10", 8'h10, 8'h77);

        // full-array load without a last marker
        reload = 1'b1; tick(); reload = 1'b0;
        ld_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            ld_data = 8'($urandom);
            tick();
            if (i == DEPTH - 2) chk("fill ld_ready@255", {31'h0, ld_ready}, 32'd1);
        end
        ld_valid = 1'b0;
        chk("fill ld_ready", {31'h0, ld_ready}, 32'd0);
        chk("fill cpu_rst_n", {31'h0, cpu_rst_n}, 32'd1);
        chk("fill ld_ptr", {24'h0, dut.ld_ptr_q}, 32'd0);

        // randomized traffic with occasional reload and reset
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(15));
            addr = 8'($urandom); din = 8'($urandom); ld_data = 8'($urandom);
            ld_valid = 1'($urandom_range(1));
            ld_last = ($urandom_range(7) == 0);
            reload = ($urandom_range(60) == 0);
            cen = 1'b1; oen = 1'b1; wen = 1'b1; den = 1'b0;
            if (r < 6) begin
                cen = 1'b0; oen = 1'b0;
            end else if (r < 9) begin
                cen = 1'b0; wen = 1'b0; den = 1'b1;
            end else if (r == 9) begin
                cen = 1'($urandom_range(1)); oen = 1'($urandom_range(1));
                den = 1'($urandom_range(1)); wen = 1'b0;
            end else if (r < 12) begin
                cen = 1'b0; den = 1'($urandom_range(1));
            end
            if (i % 400 == 399) begin
                rst = 1'b0; #2; rst = 1'b1;
            end
            tick();
        end
        cen = 1'b1; oen = 1'b1; wen = 1'b1; den = 1'b0; reload = 1'b0; ld_last = 1'b0;

        // AW=4 instance: wrap after 16 bytes, then saturate a 3-bit counter
        @(negedge clk);
        chk("dut4 reset ld_ready", {31'h0, ld_ready4}, 32'd1);
        tick();
        rst4 = 1'b1; ld_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ld_data = 8'(8'h30 + i);
            tick();
            if (i == 14) chk("wrap4 ld_ready@15", {31'h0, ld_ready4}, 32'd1);
        end
        ld_valid = 1'b0;
        chk("wrap4 ld_ready", {31'h0, ld_ready4}, 32'd0);
        chk("wrap4 cpu_rst_n", {31'h0, cpu_rst_n4}, 32'd1);
        chk("wrap4 ld_ptr", {28'h0, dut4.ld_ptr_q}, 32'd0);
        addr = 8'h0F; cen = 1'b0; oen = 1'b0;
        @(negedge clk);
        chk("wrap4 dq 0xF", {24'h0, dq4}, 32'h3F);
        tick();
        addr = 8'h03;
        @(negedge clk);
        chk("wrap4 dq 0x3", {24'h0, dq4}, 32'h33);
        repeat (4) tick();
        chk("dut4 rd_cnt 5", {29'h0, rd_cnt4}, 32'd5);
        repeat (5) tick();
        chk("dut4 rd_cnt sat", {29'h0, rd_cnt4}, 32'd7);
        cen = 1'b1; oen = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
